mem_bus_arbiter: RTL and testbench

- Shares the single Avalon-style memory bus between two CPU masters: the instruction-fetch port (read-only) and the data port (read/write, byte-enabled).
- Sits between the cpu core's fetch and load/store units and the external memory interface (address/read/write/waitrequest/writedata/byteenable/readdata).
- Arbitrates, latches the winning request, handles waitrequest stalls, routes read data back to the owner, and supports an optional stall timeout.

---
 rtl/mem_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one Avalon-style memory bus between the CPU instruction-fetch port
//   (read-only) and the data port (read/write, byte-enabled).
//   IDLE picks a winner and latches its request. BUS drives mem_* from the
//   latched copy until the request is accepted or it times out. RESP returns
//   one beat of read data to the owner.
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   i_*                          fetch port (read, address -> waitrequest, readdata, readdatavalid)
//   d_*                          data port (read, write, address, writedata, byteenable -> ...)
//   mem_*                        memory master (address, read, write, writedata, byteenable; waitrequest, readdata in)
//   owner                        0 = fetch, 1 = data (current or last grant)
//   protocol_error, bus_timeout  sticky error flags
module mem_bus_arbiter #(
  parameter int          DATA_PRIORITY = 0,
  parameter int          TIMEOUT       = 0,
  parameter logic [31:0] ABORT_DATA    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  output logic        i_readdatavalid,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic        d_readdatavalid,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        owner,
  output logic        protocol_error,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d, wr_q, wr_d;     // bus strobes
  logic        op_wr_q, op_wr_d;           // latched op; survives a timeout abort
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;             // 0: fetch wins next tie, 1: data wins
  logic        perr_q, perr_d, tout_q, tout_d, abort_q, abort_d;
  logic [15:0] cnt_q, cnt_d;

  logic d_req, grant_data, accept;
  logic [31:0] rdata_mux;

  assign d_req = d_read | d_write;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    op_wr_d = op_wr_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    tout_d  = tout_q;
    abort_d = abort_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q | (d_read & d_write);
    grant_data = 1'b0;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        cnt_d   = '0;
        if (i_read | d_req) begin
          if (i_read & d_req) grant_data = (DATA_PRIORITY != 0) ? 1'b1 : prio_q;
          else                grant_data = d_req;
          owner_d = grant_data;
          prio_d  = ~grant_data;
          if (grant_data) begin
            addr_d  = d_address;
            wdata_d = d_writedata;
            be_d    = d_byteenable;
            // read+write together resolves to a write
            op_wr_d = d_write;
          end else begin
            addr_d  = i_address;
            wdata_d = '0;
            be_d    = 4'hF;
            op_wr_d = 1'b0;
          end
          wr_d    = op_wr_d;
          rd_d    = ~op_wr_d;
          state_d = BUS;
        end
      end
      BUS: begin
        if (rd_q | wr_q) begin
          if (!mem_waitrequest) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = rd_q ? RESP : IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
            if (TIMEOUT != 0 && cnt_d == 16'(TIMEOUT)) begin
              // drop strobes now; next cycle is the abort handshake
              rd_d    = 1'b0;
              wr_d    = 1'b0;
              tout_d  = 1'b1;
              abort_d = 1'b1;
            end
          end
        end else begin
          // abort cycle: strobes already low, owner sees waitrequest low
          state_d = op_wr_q ? IDLE : RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      op_wr_q <= 1'b0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      perr_q  <= 1'b0;
      tout_q  <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      op_wr_q <= op_wr_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      perr_q  <= perr_d;
      tout_q  <= tout_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  // Owner handshake: follows mem_waitrequest while strobing, forced low in
  // the abort cycle.
  assign accept = (state_q == BUS) & ((rd_q | wr_q) ? ~mem_waitrequest : 1'b1);
  assign i_waitrequest = ~(accept & ~owner_q);
  assign d_waitrequest = ~(accept &  owner_q);

  assign rdata_mux       = abort_q ? ABORT_DATA : mem_readdata;
  assign i_readdatavalid = (state_q == RESP) & ~owner_q;
  assign d_readdatavalid = (state_q == RESP) &  owner_q;
  assign i_readdata      = i_readdatavalid ? rdata_mux : '0;
  assign d_readdata      = d_readdatavalid ? rdata_mux : '0;

  assign mem_address    = addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign owner          = owner_q;
  assign protocol_error = perr_q;
  assign bus_timeout    = tout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read, d_read, d_write, mem_waitrequest;
  logic [31:0] i_address, d_address, d_writedata, mem_readdata;
  logic [3:0]  d_byteenable;

  // dut0: round-robin, TIMEOUT=4
  logic        i_waitrequest, i_readdatavalid, d_waitrequest, d_readdatavalid;
  logic [31:0] i_readdata, d_readdata, mem_address, mem_writedata;
  logic        mem_read, mem_write, owner, protocol_error, bus_timeout;
  logic [3:0]  mem_byteenable;
  // dut1: data priority, no timeout
  logic        p_i_waitrequest, p_i_readdatavalid, p_d_waitrequest, p_d_readdatavalid;
  logic [31:0] p_i_readdata, p_d_readdata, p_mem_address, p_mem_writedata;
  logic        p_mem_read, p_mem_write, p_owner, p_protocol_error, p_bus_timeout;
  logic [3:0]  p_mem_byteenable;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_PRIORITY(0), .TIMEOUT(4)) dut0 (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_waitrequest(i_waitrequest),
    .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest),
    .d_readdata(d_readdata), .d_readdatavalid(d_readdatavalid),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .owner(owner), .protocol_error(protocol_error), .bus_timeout(bus_timeout)
  );

  mem_bus_arbiter #(.DATA_PRIORITY(1), .TIMEOUT(0)) dut1 (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_waitrequest(p_i_waitrequest),
    .i_readdata(p_i_readdata), .i_readdatavalid(p_i_readdatavalid),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(p_d_waitrequest),
    .d_readdata(p_d_readdata), .d_readdatavalid(p_d_readdatavalid),
    .mem_address(p_mem_address), .mem_read(p_mem_read), .mem_write(p_mem_write),
    .mem_writedata(p_mem_writedata), .mem_byteenable(p_mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .owner(p_owner), .protocol_error(p_protocol_error), .bus_timeout(p_bus_timeout)
  );

  // req = {i_read, d_read, d_write}; ef = {mem_read, mem_write, i_wait, d_wait, i_valid, d_valid, owner}
  typedef struct {
    logic [2:0]  req;
    logic [31:0] ia, da, dwd;
    logic        mw;
    logic [6:0]  ef;
    logic [31:0] eaddr, erdata;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [2:0] req, logic [31:0] ia, logic [31:0] da, logic [31:0] dwd,
                              logic mw, logic [6:0] ef, logic [31:0] eaddr, logic [31:0] erdata);
    vec_t v;
    v.req = req; v.ia = ia; v.da = da; v.dwd = dwd; v.mw = mw;
    v.ef = ef; v.eaddr = eaddr; v.erdata = erdata;
    return v;
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0; d_byteenable = 4'hF;
    mem_waitrequest = 1'b0; mem_readdata = 32'h8C010064;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    vecs[0]  = mk(3'b101, 32'h100, 32'd200, 32'd123, 1'b0, 7'b0011000, 32'h0,       32'h0);
    vecs[1]  = mk(3'b101, 32'h100, 32'd200, 32'd123, 1'b0, 7'b1001000, 32'h100,     32'h0);
    vecs[2]  = mk(3'b101, 32'h100, 32'd200, 32'd123, 1'b0, 7'b0011100, 32'h100,     32'h8C010064);
    vecs[3]  = mk(3'b101, 32'h100, 32'd200, 32'd123, 1'b0, 7'b0011000, 32'h100,     32'h0);
    vecs[4]  = mk(3'b101, 32'h100, 32'd200, 32'd123, 1'b0, 7'b0110001, 32'd200,     32'h0);
    vecs[5]  = mk(3'b101, 32'h100, 32'd200, 32'd123, 1'b0, 7'b0011001, 32'd200,     32'h0);
    vecs[6]  = mk(3'b101, 32'h100, 32'd200, 32'd123, 1'b0, 7'b1001000, 32'h100,     32'h0);
    vecs[7]  = mk(3'b101, 32'h100, 32'd200, 32'd123, 1'b0, 7'b0011100, 32'h100,     32'h8C010064);
    vecs[8]  = mk(3'b000, 32'h100, 32'd200, 32'd123, 1'b0, 7'b0011000, 32'h100,     32'h0);
    vecs[9]  = mk(3'b100, 32'hBFC00000, 32'h0, 32'h0, 1'b0, 7'b0011000, 32'h100,     32'h0);
    vecs[10] = mk(3'b100, 32'hBFC00000, 32'h0, 32'h0, 1'b0, 7'b1001000, 32'hBFC00000, 32'h0);
    vecs[11] = mk(3'b000, 32'hBFC00000, 32'h0, 32'h0, 1'b0, 7'b0011100, 32'hBFC00000, 32'h8C010064);

    // reset state
    step();
    step();
    @(negedge clk);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk32("rst_mem_address", mem_address, 32'h0);
    chk1("rst_i_wait", i_waitrequest, 1'b1);
    chk1("rst_d_wait", d_waitrequest, 1'b1);
    chk1("rst_i_valid", i_readdatavalid, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk1("rst_perr", protocol_error, 1'b0);
    chk1("rst_tout", bus_timeout, 1'b0);
    step();
    reset = 1'b0;

    // round-robin (fetch, data, fetch) then a lone fetch read
    for (int i = 0; i < 12; i++) begin
      {i_read, d_read, d_write} = vecs[i].req;
      i_address = vecs[i].ia; d_address = vecs[i].da; d_writedata = vecs[i].dwd;
      mem_waitrequest = vecs[i].mw;
      @(negedge clk);
      chk1($sformatf("v%0d_mem_read", i), mem_read, vecs[i].ef[6]);
      chk1($sformatf("v%0d_mem_write", i), mem_write, vecs[i].ef[5]);
      chk1($sformatf("v%0d_i_wait", i), i_waitrequest, vecs[i].ef[4]);
      chk1($sformatf("v%0d_d_wait", i), d_waitrequest, vecs[i].ef[3]);
      chk1($sformatf("v%0d_i_valid", i), i_readdatavalid, vecs[i].ef[2]);
      chk1($sformatf("v%0d_d_valid", i), d_readdatavalid, vecs[i].ef[1]);
      chk1($sformatf("v%0d_owner", i), owner, vecs[i].ef[0]);
      chk32($sformatf("v%0d_mem_address", i), mem_address, vecs[i].eaddr);
      if (vecs[i].ef[2]) chk32($sformatf("v%0d_i_rdata", i), i_readdata, vecs[i].erdata);
      if (vecs[i].ef[5]) begin
        chk32($sformatf("v%0d_mem_wdata", i), mem_writedata, 32'd123);
        chk32($sformatf("v%0d_mem_be", i), {28'h0, mem_byteenable}, 32'hF);
      end
      step();
    end

    // data priority: data wins both ties, fetch never released
    do_reset();
    i_read = 1'b1; i_address = 32'h100; d_read = 1'b1; d_address = 32'h40;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk1($sformatf("prio_c%0d_i_wait", c), p_i_waitrequest, 1'b1);
      if (c == 1 || c == 4) begin
        chk1($sformatf("prio_c%0d_owner", c), p_owner, 1'b1);
        chk1($sformatf("prio_c%0d_d_wait", c), p_d_waitrequest, 1'b0);
        chk32($sformatf("prio_c%0d_addr", c), p_mem_address, 32'h40);
      end
      step();
    end

    // stall: 3 waitrequest cycles on a data read, address held stable
    do_reset();
    d_read = 1'b1; d_address = 32'd101; mem_waitrequest = 1'b1; mem_readdata = 32'd404;
    @(negedge clk); chk1("stall_c0_d_wait", d_waitrequest, 1'b1);
    step();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk1($sformatf("stall_c%0d_d_wait", c), d_waitrequest, 1'b1);
      chk1($sformatf("stall_c%0d_mem_read", c), mem_read, 1'b1);
      chk32($sformatf("stall_c%0d_addr", c), mem_address, 32'd101);
      step();
      d_address = 32'd0;
    end
    mem_waitrequest = 1'b0;
    @(negedge clk);
    chk1("stall_acc_d_wait", d_waitrequest, 1'b0);
    chk32("stall_acc_addr", mem_address, 32'd101);
    step();
    d_read = 1'b0;
    @(negedge clk);
    chk1("stall_d_valid", d_readdatavalid, 1'b1);
    chk32("stall_d_rdata", d_readdata, 32'd404);
    chk1("stall_i_valid", i_readdatavalid, 1'b0);
    step();

    // timeout: memory never releases a fetch read
    do_reset();
    i_read = 1'b1; i_address = 32'hBFC00000; mem_waitrequest = 1'b1;
    step();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk1($sformatf("to_c%0d_i_wait", c), i_waitrequest, 1'b1);
      chk1($sformatf("to_c%0d_mem_read", c), mem_read, 1'b1);
      chk1($sformatf("to_c%0d_tout", c), bus_timeout, 1'b0);
      step();
    end
    @(negedge clk);
    chk1("to_abort_i_wait", i_waitrequest, 1'b0);
    chk1("to_abort_mem_read", mem_read, 1'b0);
    chk1("to_abort_tout", bus_timeout, 1'b1);
    step();
    i_read = 1'b0;
    @(negedge clk);
    chk1("to_resp_i_valid", i_readdatavalid, 1'b1);
    chk32("to_resp_i_rdata", i_readdata, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk1("to_sticky_tout", bus_timeout, 1'b1);
    chk1("to_after_i_valid", i_readdatavalid, 1'b0);
    step();

    // reset while in BUS drops the transfer
    do_reset();
    i_read = 1'b1; i_address = 32'h200; mem_waitrequest = 1'b1;
    step();
    @(negedge clk);
    chk1("rb_bus_mem_read", mem_read, 1'b1);
    reset = 1'b1; i_read = 1'b0; mem_waitrequest = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk1("rb_mem_read", mem_read, 1'b0);
    chk1("rb_i_wait", i_waitrequest, 1'b1);
    chk1("rb_d_wait", d_waitrequest, 1'b1);
    chk1("rb_i_valid", i_readdatavalid, 1'b0);
    chk1("rb_tout", bus_timeout, 1'b0);
    step();
    @(negedge clk);
    chk1("rb_next_i_valid", i_readdatavalid, 1'b0);
    chk1("rb_next_mem_read", mem_read, 1'b0);
    step();

    // read+write together: performed as a write, sticky error
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h80; d_writedata = 32'h55; d_byteenable = 4'h3;
    @(negedge clk); chk1("pe_c0_perr", protocol_error, 1'b0);
    step();
    @(negedge clk);
    chk1("pe_perr", protocol_error, 1'b1);
    chk1("pe_mem_write", mem_write, 1'b1);
    chk1("pe_mem_read", mem_read, 1'b0);
    chk32("pe_wdata", mem_writedata, 32'h55);
    chk32("pe_be", {28'h0, mem_byteenable}, 32'h3);
    chk1("pe_d_wait", d_waitrequest, 1'b0);
    step();
    d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    chk1("pe_no_valid", d_readdatavalid, 1'b0);
    chk1("pe_sticky1", protocol_error, 1'b1);
    step();
    step();
    @(negedge clk); chk1("pe_sticky2", protocol_error, 1'b1);
    do_reset();
    @(negedge clk); chk1("pe_cleared", protocol_error, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
